// File: rtl/button_cmd_conditioner_if.sv
// Button/command bundle between the board pins and the stepper controller.
interface button_cmd_conditioner_if;
  logic [1:0] btn_raw;
  logic [1:0] cmd;
  logic       jog;
  logic       busy;

  modport master (output btn_raw, input cmd, jog, busy);
  modport slave  (input btn_raw, output cmd, jog, busy);
endinterface

// File: rtl/button_cmd_conditioner.sv
// Two-button conditioner: 2-flop sync, per-bit debounce, mutual exclusion into
// a stepper command, and a jog pulse with hold-to-repeat.
//
// state    | meaning
// IDLE     | no command active, repeat counter idle
// HOLD     | command entered, waiting REPEAT_DELAY before auto-repeat
// REPEAT   | auto-repeat, jog every REPEAT_PERIOD cycles
module button_cmd_conditioner #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int REPEAT_DELAY    = 500000,
  parameter int REPEAT_PERIOD   = 100000,
  parameter int CNT_W           = 20
) (
  input logic                      system1000,
  input logic                      system1000_rstn,
  button_cmd_conditioner_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HOLD   = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic [1:0]       r_deb;
  logic [CNT_W-1:0] r_db_cnt [2];
  logic [1:0]       r_cmd;
  logic             r_jog;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_rep_cnt;
  logic [1:0]       w_cmd_next;
  logic             w_busy;

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Any sample agreeing with the current level restarts the stability count.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      r_deb <= '0;
      for (int b = 0; b < 2; b++) r_db_cnt[b] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (r_sync2[b] == r_deb[b]) begin
          r_db_cnt[b] <= '0;
        end else if (r_db_cnt[b] == DB_LAST) begin
          r_deb[b]    <= r_sync2[b];
          r_db_cnt[b] <= '0;
        end else begin
          r_db_cnt[b] <= r_db_cnt[b] + CNT_ONE;
        end
      end
    end
  end

  assign w_busy = (r_db_cnt[0] != '0) || (r_db_cnt[1] != '0);

  always_comb begin
    w_cmd_next = 2'b00;
    case (r_deb)
      2'b01:   w_cmd_next = 2'b01;
      2'b10:   w_cmd_next = 2'b10;
      default: w_cmd_next = 2'b00;
    endcase
  end

  // A change to a different non-stop command (01<->10) counts as a fresh entry.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      r_cmd     <= 2'b00;
      r_jog     <= 1'b0;
      r_state   <= S_IDLE;
      r_rep_cnt <= '0;
    end else begin
      r_cmd <= w_cmd_next;
      r_jog <= 1'b0;
      if (w_cmd_next == 2'b00) begin
        r_state   <= S_IDLE;
        r_rep_cnt <= '0;
      end else if (w_cmd_next != r_cmd) begin
        r_jog     <= 1'b1;
        r_rep_cnt <= '0;
        r_state   <= S_HOLD;
      end else begin
        case (r_state)
          S_HOLD: begin
            if (r_rep_cnt == RD_LAST) begin
              r_jog     <= 1'b1;
              r_rep_cnt <= '0;
              r_state   <= S_REPEAT;
            end else begin
              r_rep_cnt <= r_rep_cnt + CNT_ONE;
            end
          end
          S_REPEAT: begin
            if (r_rep_cnt == RP_LAST) begin
              r_jog     <= 1'b1;
              r_rep_cnt <= '0;
            end else begin
              r_rep_cnt <= r_rep_cnt + CNT_ONE;
            end
          end
          default: begin
            r_state   <= S_IDLE;
            r_rep_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign bus.cmd  = r_cmd;
  assign bus.jog  = r_jog;
  assign bus.busy = w_busy;

endmodule

// File: tb/tb_button_cmd_conditioner.sv
// Randomized + directed bench for button_cmd_conditioner against a
// window/age based reference model.
module tb_button_cmd_conditioner;
  localparam int DB = 8;
  localparam int RD = 20;
  localparam int RP = 5;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  button_cmd_conditioner_if bus ();

  button_cmd_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .CNT_W          (8)
  ) dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .bus             (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int jog_q[$];

  // Reference model: a button level flips once the last DB synchronised
  // samples all disagree with it; jog timing derives from the hold age.
  logic [1:0] hist[$];
  logic [1:0] m_deb;
  logic [1:0] m_cmd;
  logic       m_jog;
  logic       m_busy;
  int         m_age;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [1:0] cmd_of(input logic [1:0] d);
    if (d == 2'b01) return 2'b01;
    if (d == 2'b10) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < DB + 2; i++) hist.push_back(2'b00);
    m_deb = 2'b00; m_cmd = 2'b00; m_jog = 1'b0; m_busy = 1'b0; m_age = -1;
  endtask

  task automatic model_edge(input logic [1:0] raw);
    logic [1:0] nc;
    logic       all_diff;
    hist.push_back(raw);
    void'(hist.pop_front());
    nc = cmd_of(m_deb);
    m_busy = 1'b0;
    for (int b = 0; b < 2; b++) begin
      all_diff = 1'b1;
      for (int i = 0; i < DB; i++) if (hist[i][b] == m_deb[b]) all_diff = 1'b0;
      if (all_diff) m_deb[b] = ~m_deb[b];
      if (hist[DB-1][b] != m_deb[b]) m_busy = 1'b1;
    end
    if (nc == 2'b00) begin
      m_age = -1; m_jog = 1'b0;
    end else if (nc != m_cmd) begin
      m_age = 0; m_jog = 1'b1;
    end else begin
      m_age++;
      m_jog = (m_age >= RD) && (((m_age - RD) % RP) == 0);
    end
    m_cmd = nc;
  endtask

  task automatic step(input logic [1:0] raw);
    @(negedge clk);
    bus.btn_raw = raw;
    @(posedge clk);
    cyc++;
    if (rstn) model_edge(raw);
    #1;
    if (bus.jog) jog_q.push_back(cyc);
    chk("cmd", 32'(bus.cmd), 32'(m_cmd));
    chk("jog", 32'(bus.jog), 32'(m_jog));
    chk("busy", 32'(bus.busy), 32'(m_busy));
  endtask

  task automatic run_until_cmd(input logic [1:0] raw, input logic [1:0] tgt,
                               input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      step(raw);
      if (bus.cmd == tgt) begin
        n = i;
        break;
      end
    end
  endtask

  // Asynchronous reset pulse placed between edges, held across one edge.
  task automatic reset_pulse(input logic [1:0] raw);
    rstn = 1'b0;
    model_reset();
    #2;
    chk("arst_cmd", 32'(bus.cmd), 32'd0);
    chk("arst_jog", 32'(bus.jog), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    step(raw);
    rstn = 1'b1;
  endtask

  task automatic random_phase();
    logic [1:0] pat;
    logic [1:0] r;
    int len;
    pat = 2'($urandom_range(0, 3));
    len = $urandom_range(1, 60);
    if ($urandom_range(0, 19) == 0) reset_pulse(pat);
    for (int i = 0; i < len; i++) begin
      r = pat;
      if ($urandom_range(0, 9) == 0) r = r ^ 2'($urandom_range(1, 3));
      step(r);
    end
  endtask

  initial begin
    int n;
    int t0;
    bus.btn_raw = 2'b01;
    model_reset();

    // reset held with forward pressed, then release
    repeat (10) step(2'b01);
    rstn = 1'b1;
    run_until_cmd(2'b01, 2'b01, 30, n);
    chk("rst_lat", 32'(n), 32'd11);
    chk("rst_jog", 32'(bus.jog), 32'd1);
    run_until_cmd(2'b00, 2'b00, 30, n);
    repeat (5) step(2'b00);

    // glitch one cycle short of the debounce window
    jog_q.delete();
    repeat (7) step(2'b01);
    repeat (20) step(2'b00);
    chk("glitch_jogs", 32'(jog_q.size()), 32'd0);
    chk("glitch_cmd", 32'(bus.cmd), 32'd0);
    chk("glitch_busy", 32'(bus.busy), 32'd0);

    // auto-repeat over a 60-cycle hold
    jog_q.delete();
    run_until_cmd(2'b01, 2'b01, 30, n);
    chk("rep_entry_lat", 32'(n), 32'd11);
    t0 = cyc;
    repeat (60 - n) step(2'b01);
    chk("rep_count", 32'(jog_q.size()), 32'd7);
    if (jog_q.size() > 0) chk("rep_first", 32'(jog_q[0] - t0), 32'd0);
    for (int k = 1; k < jog_q.size() && k < 4; k++)
      chk("rep_offset", 32'(jog_q[k] - t0), 32'(RD + RP * (k - 1)));
    run_until_cmd(2'b00, 2'b00, 30, n);
    chk("rel_lat", 32'(n), 32'd11);
    jog_q.delete();
    repeat (20) step(2'b00);
    chk("rel_nojog", 32'(jog_q.size()), 32'd0);

    // both held = stop, then reverse alone
    run_until_cmd(2'b01, 2'b01, 30, n);
    repeat (5) step(2'b01);
    run_until_cmd(2'b11, 2'b00, 30, n);
    chk("mx_stop_lat", 32'(n), 32'd11);
    repeat (5) step(2'b11);
    run_until_cmd(2'b10, 2'b10, 30, n);
    chk("mx_rev_lat", 32'(n), 32'd11);
    chk("mx_rev_jog", 32'(bus.jog), 32'd1);
    run_until_cmd(2'b00, 2'b00, 30, n);
    repeat (5) step(2'b00);

    // bounce on reverse, then stable high
    jog_q.delete();
    for (int i = 0; i < 30; i++) step((((i / 3) % 2) == 0) ? 2'b10 : 2'b00);
    run_until_cmd(2'b10, 2'b10, 30, n);
    chk("bnc_lat", 32'(n), 32'd11);
    repeat (10) step(2'b10);
    chk("bnc_jogs", 32'(jog_q.size()), 32'd1);

    // reset while auto-repeating
    repeat (30) step(2'b10);
    reset_pulse(2'b10);
    jog_q.delete();
    run_until_cmd(2'b10, 2'b10, 30, n);
    chk("mid_rst_lat", 32'(n), 32'd11);
    chk("mid_rst_jog", 32'(bus.jog), 32'd1);
    chk("mid_rst_jogs", 32'(jog_q.size()), 32'd1);

    for (int p = 0; p < 80; p++) random_phase();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
